uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_tx_8n1` transmitter between `N_REQ` byte requesters in the `hclk` domain. It grants one requester at a time and drives the transmitter's `tx_data`/`tx_start` inputs. It completes a full start/busy handshake against the transmitter's `tx_busy`, which toggles on the slower baud clock, before granting the next requester. It sits beside `uart_8n1` in the top level, between the byte sources (status reporters, echo path, debug dump) and the transmit port.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_pick.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter and the round-robin
// selector (which the RX dispatcher will also use).
//   arb_state_t : arbiter FSM states (IDLE, START, SEND)
//   UART_DATA_W : UART byte width
//   id_width()  : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } arb_state_t;

  // Index width for n requesters; at least one bit so the port never collapses.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin selector. The search starts at ptr and wraps
// modulo N; the first asserted request in that order wins.
//   N, W  : number of requesters, index width
//   req   : in  [N-1:0] request vector
//   ptr   : in  [W-1:0] highest-priority index
//   valid : out any request asserted
//   idx   : out winning index (equals ptr when nothing is requested)
// ---------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  // cand[k] is the requester examined k-th in the search order.
  logic [W-1:0] cand [N];
  logic [N-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign cand[gi] = W'((int'(ptr) + gi) % N);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Scan from the back so the earliest hit in the search order is kept.
  always_comb begin
    valid = |hit;
    idx   = cand[0];
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one 8N1 transmitter between N_REQ byte requesters. One requester is
// granted at a time; tx_start is held until the transmitter's (synchronized)
// busy flag rises, then the arbiter waits for busy to fall before the next
// grant. Grant priority rotates past the last served requester.
//   hclk, rst      : system clock, synchronous active-high reset
//   req            : in  [N_REQ-1:0]   requests, held until ack/err
//   req_data       : in  [8*N_REQ-1:0] byte i at [8i+7:8i]
//   ack            : out [N_REQ-1:0]   one-cycle pulse, byte taken
//   err            : out [N_REQ-1:0]   one-cycle pulse, start timed out
//   grant_id       : out current / last granted index
//   uart_tx_data   : out byte to the transmitter, held until next grant
//   uart_tx_start  : out start strobe to the transmitter
//   uart_tx_busy   : in  transmitter busy (asynchronous to hclk)
// Optional feature macro: UART_ARB_TIMEOUT_EN -- when defined, a START phase
// that sees no busy within TIMEOUT_CYCLES cycles is abandoned with err.
// Without it START waits indefinitely and err is constant zero.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                         hclk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  output logic [N_REQ-1:0]             err,
  output logic [id_width(N_REQ)-1:0]   grant_id,
  output logic [UART_DATA_W-1:0]       uart_tx_data,
  output logic                         uart_tx_start,
  input  logic                         uart_tx_busy
);

  localparam int GID_W = id_width(N_REQ);

  arb_state_t             state_reg;
  logic                   busy_meta_reg;
  logic                   busy_s_reg;
  logic [GID_W-1:0]       ptr_reg;
  logic [GID_W-1:0]       grant_reg;
  logic [UART_DATA_W-1:0] data_reg;
  logic                   start_reg;
  logic [N_REQ-1:0]       ack_reg;

  logic                   pick_valid;
  logic [GID_W-1:0]       pick_idx;
  logic [GID_W-1:0]       ptr_next;

  uart_rr_pick #(
    .N (N_REQ),
    .W (GID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Priority moves to the requester after the one just served.
  assign ptr_next = (grant_reg == GID_W'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  // The counter holds k-1 in the k-th START cycle; firing at TIMEOUT_CYCLES-1
  // makes err visible in START cycle TIMEOUT_CYCLES+1.
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]      timeout_cnt_reg;
  logic [N_REQ-1:0] err_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(16'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge hclk) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_meta_reg <= 1'b0;
      busy_s_reg    <= 1'b0;
      ptr_reg       <= '0;
      grant_reg     <= '0;
      data_reg      <= '0;
      start_reg     <= 1'b0;
      ack_reg       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_cnt_reg <= '0;
      err_reg         <= '0;
`endif
    end else begin
      busy_meta_reg <= uart_tx_busy;
      busy_s_reg    <= busy_meta_reg;
      ack_reg       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_reg       <= '0;
`endif
      case (state_reg)
        IDLE: begin
          // A busy transmitter is still draining a frame (possibly one
          // started before a reset); hold off new grants until it ends.
          if (!busy_s_reg && pick_valid) begin
            data_reg  <= req_data[pick_idx*UART_DATA_W +: UART_DATA_W];
            grant_reg <= pick_idx;
            start_reg <= 1'b1;
            state_reg <= START;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_cnt_reg <= '0;
`endif
          end
        end
        START: begin
          // Start stays high until busy is seen, so a transmitter on a slow
          // divided clock always catches it. Busy beats a same-cycle timeout.
          if (busy_s_reg) begin
            ack_reg[grant_reg] <= 1'b1;
            start_reg          <= 1'b0;
            ptr_reg            <= ptr_next;
            state_reg          <= SEND;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (timeout_cnt_reg == TIMEOUT_LIM) begin
            err_reg[grant_reg] <= 1'b1;
            start_reg          <= 1'b0;
            ptr_reg            <= ptr_next;
            state_reg          <= IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
          end
`endif
        end
        SEND: begin
          if (!busy_s_reg) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ack           = ack_reg;
  assign grant_id      = grant_reg;
  assign uart_tx_data  = data_reg;
  assign uart_tx_start = start_reg;

`ifdef UART_ARB_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=16). A simple
// transmitter model raises busy a few cycles after it sees start and holds it
// for a programmable number of cycles. Prints one line per completed transfer.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int BUSY_DELAY = 5;

  logic          hclk;
  logic          rst;
  logic [N-1:0]  req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  ack;
  logic [N-1:0]  err;
  logic [1:0]    grant_id;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_busy;

  logic busy_model;
  logic busy_force;
  bit   model_en;
  int   busy_hold;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  int multi_cnt = 0;

  assign uart_tx_busy = busy_model | busy_force;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .hclk          (hclk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .err           (err),
    .grant_id      (grant_id),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  // Transmitter model: start seen -> busy after BUSY_DELAY cycles for busy_hold.
  initial begin
    busy_model = 1'b0;
    forever begin
      @(posedge hclk);
      #1;
      if (model_en && uart_tx_start) begin
        repeat (BUSY_DELAY) @(posedge hclk);
        #1 busy_model = 1'b1;
        repeat (busy_hold) @(posedge hclk);
        #1 busy_model = 1'b0;
      end
    end
  end

  always @(negedge hclk) begin
    if (ack != '0) ack_cnt++;
    if (err != '0) err_cnt++;
    if ($countones(ack | err) > 1) multi_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input int idx, input logic [7:0] byte_exp, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (ack == '0 && n < 400);
    check({tag, "_timeout"}, 32'(n >= 400), 0);
    check({tag, "_ack"}, 32'(ack), 32'(1 << idx));
    check({tag, "_byte"}, 32'(uart_tx_data), 32'(byte_exp));
    $display("tx req %0d byte %02h", grant_id, uart_tx_data);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (uart_tx_busy && n < 400) begin
      @(negedge hclk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n >= 400), 0);
    repeat (4) @(negedge hclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sb, a0, k;
    int exp_acks;
    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    busy_force = 1'b0;
    model_en   = 1'b1;
    busy_hold  = 100;
    repeat (3) @(negedge hclk);

    // Reset state
    check("rst_start", 32'(uart_tx_start), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_data", 32'(uart_tx_data), 0);
    rst = 1'b0;

    // Single request: start and data one cycle after req is seen
    @(negedge hclk);
    req_data[7:0] = 8'h41;
    req = 4'b0001;
    @(negedge hclk);
    check("t1_start", 32'(uart_tx_start), 1);
    check("t1_data", 32'(uart_tx_data), 32'h41);
    check("t1_gid", 32'(grant_id), 0);
    wait_ack(0, 8'h41, "t1");
    req = '0;
    @(negedge hclk);
    check("t1_start_fall", 32'(uart_tx_start), 0);
    n = 0;
    sb = 0;
    while (uart_tx_busy && n < 300) begin
      if (uart_tx_start) sb++;
      @(negedge hclk);
      n++;
    end
    check("t1_busy_timeout", 32'(n >= 300), 0);
    check("t1_no_start_busy", 32'(sb), 0);
    repeat (5) @(negedge hclk);
    check("t1_ack_count", 32'(ack_cnt), 1);

    // Round-robin order from ptr=0
    rst = 1'b1;
    @(negedge hclk);
    rst = 1'b0;
    busy_hold = 20;
    req_data = 32'h40302010;
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      wait_ack(i, 8'((i + 1) * 16), "t2");
      req[i] = 1'b0;
    end
    wait_idle("t2");

    // Fairness: serving requester 1 moves ptr to 2; then 0101 serves 2 before 0
    req_data[15:8] = 8'h55;
    req = 4'b0010;
    wait_ack(1, 8'h55, "t3a");
    req = '0;
    req_data[7:0]   = 8'hA0;
    req_data[23:16] = 8'hC2;
    req = 4'b0101;
    wait_ack(2, 8'hC2, "t3b");
    req[2] = 1'b0;
    wait_ack(0, 8'hA0, "t3c");
    req = '0;
    wait_idle("t3");

    // Already busy: no start until busy falls, then three cycles of latency
    busy_force = 1'b1;
    repeat (4) @(negedge hclk);
    req_data[31:24] = 8'h77;
    req = 4'b1000;
    sb = 0;
    repeat (20) begin
      @(negedge hclk);
      if (uart_tx_start) sb++;
    end
    check("t4_blocked", 32'(sb), 0);
    busy_force = 1'b0;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!uart_tx_start && n < 20);
    check("t4_latency", 32'(n), 3);
    check("t4_gid", 32'(grant_id), 3);
    wait_ack(3, 8'h77, "t4");
    req = '0;
    wait_idle("t4");

    // Reset mid-transfer while the raw busy has risen but START is still active
    req_data[7:0] = 8'h99;
    req = 4'b0001;
    @(negedge hclk);
    check("t5_start", 32'(uart_tx_start), 1);
    n = 0;
    while (!uart_tx_busy && n < 20) begin
      @(negedge hclk);
      n++;
    end
    check("t5_busy_timeout", 32'(n >= 20), 0);
    check("t5_still_start", 32'(uart_tx_start), 1);
    a0 = ack_cnt;
    rst = 1'b1;
    @(negedge hclk);
    rst = 1'b0;
    req = '0;
    check("t5_rst_start", 32'(uart_tx_start), 0);
    check("t5_rst_ack", 32'(ack), 0);
    repeat (3) @(negedge hclk);
    req = 4'b0001;
    sb = 0;
    n = 0;
    while (uart_tx_busy && n < 100) begin
      if (uart_tx_start) sb++;
      @(negedge hclk);
      n++;
    end
    check("t5_blocked", 32'(sb), 0);
    check("t5_no_ack", 32'(ack_cnt), 32'(a0));
    wait_ack(0, 8'h99, "t5");
    req = '0;
    wait_idle("t5");

`ifdef UART_ARB_TIMEOUT_EN
    // Timeout: ptr is 1, busy never rises; err in START cycle 17
    model_en = 1'b0;
    req_data[15:8]  = 8'hB1;
    req_data[23:16] = 8'hB2;
    req = 4'b0110;
    n = 0;
    do begin
      @(negedge hclk);
      n++;
    end while (!uart_tx_start && n < 5);
    check("t6_start", 32'(uart_tx_start), 1);
    check("t6_gid", 32'(grant_id), 1);
    k = 1;
    while (err == '0 && k < 40) begin
      @(negedge hclk);
      k++;
    end
    check("t6_err_cycle", 32'(k), 17);
    check("t6_err", 32'(err), 32'b0010);
    check("t6_start_drop", 32'(uart_tx_start), 0);
    $display("tx req %0d timed out", grant_id);
    req[1] = 1'b0;
    model_en = 1'b1;
    @(negedge hclk);
    check("t6_next_start", 32'(uart_tx_start), 1);
    check("t6_next_gid", 32'(grant_id), 2);
    wait_ack(2, 8'hB2, "t6");
    req = '0;
    wait_idle("t6");
    exp_acks = 11;
    check("err_count", 32'(err_cnt), 1);
`else
    exp_acks = 10;
    check("err_count", 32'(err_cnt), 0);
`endif

    check("ack_total", 32'(ack_cnt), 32'(exp_acks));
    check("onehot", 32'(multi_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
